// File: rtl/addr_counter_pkg.sv
// Shared definitions for the address counter: default byte width and the
// operation code chosen by the priority decode.
package addr_counter_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_LOAD = 3'd1,
        OP_REL  = 3'd2,
        OP_INC  = 3'd3,
        OP_DEC  = 3'd4
    } op_e;

    // Load beats relative add beats a lone INC or DEC; INC with DEC cancels.
    function automatic op_e decode_op(
        input logic cs,
        input logic any_we,
        input logic rel,
        input logic inc,
        input logic dec
    );
        if (!cs)          return OP_HOLD;
        if (any_we)       return OP_LOAD;
        if (rel)          return OP_REL;
        if (inc && !dec)  return OP_INC;
        if (dec && !inc)  return OP_DEC;
        return OP_HOLD;
    endfunction

endpackage

// File: rtl/addr_counter_next.sv
// Combinational next-count logic: per-byte load, signed relative add and
// modular increment/decrement of the full address word.
module addr_counter_next
    import addr_counter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_BYTES  = 2
) (
    input  logic [NUM_BYTES*DATA_WIDTH-1:0] i_count,
    input  op_e                             i_op,
    input  logic [NUM_BYTES-1:0]            i_we,
    input  logic [DATA_WIDTH-1:0]           i_data,
    output logic [NUM_BYTES*DATA_WIDTH-1:0] o_next
);

    localparam int AW = NUM_BYTES * DATA_WIDTH;

    logic signed [DATA_WIDTH-1:0] w_data_s;
    logic        [AW-1:0]         w_sext;

    assign w_data_s = i_data;
    assign w_sext   = AW'(w_data_s);

    always_comb begin
        o_next = i_count;
        case (i_op)
            OP_LOAD: begin
                // Bytes are replaced independently; nothing carries across slices.
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (i_we[b]) begin
                        o_next[b*DATA_WIDTH +: DATA_WIDTH] = i_data;
                    end
                end
            end
            OP_REL:  o_next = i_count + w_sext;
            OP_INC:  o_next = i_count + AW'(1);
            OP_DEC:  o_next = i_count - AW'(1);
            default: o_next = i_count;
        endcase
    end

endmodule

// File: rtl/addr_counter.sv
// Multi-byte program counter / stack pointer: state register, byte read mux,
// tri-state data and address drivers, and wrap/zero flags.
module addr_counter
    import addr_counter_pkg::*;
#(
    parameter int                                DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int                                NUM_BYTES   = 2,
    parameter logic [NUM_BYTES*DATA_WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             CS,
    input  logic [NUM_BYTES-1:0]             WE,
    input  logic [NUM_BYTES-1:0]             OE,
    input  logic                             OE_A,
    input  logic                             INC,
    input  logic                             DEC,
    input  logic                             REL,
    inout  wire  [DATA_WIDTH-1:0]            data,
    output logic [NUM_BYTES*DATA_WIDTH-1:0]  address,
    output logic [NUM_BYTES*DATA_WIDTH-1:0]  count_out,
    output logic                             carry,
    output logic                             borrow,
    output logic                             zero
);

    localparam int AW = NUM_BYTES * DATA_WIDTH;

    logic [AW-1:0]         r_count;
    logic [AW-1:0]         w_next;
    op_e                   w_op;
    logic                  w_any_we;
    logic                  w_oe_any;
    logic [DATA_WIDTH-1:0] w_rd_byte;

    assign w_any_we = |WE;
    assign w_op     = decode_op(CS, w_any_we, REL, INC, DEC);

    addr_counter_next #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_BYTES  (NUM_BYTES)
    ) u_next (
        .i_count (r_count),
        .i_op    (w_op),
        .i_we    (WE),
        .i_data  (data),
        .o_next  (w_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= RESET_VALUE;
        end else if (w_op != OP_HOLD) begin
            r_count <= w_next;
        end
    end

    // Scan from the top down so the lowest enabled byte wins.
    always_comb begin
        w_oe_any  = 1'b0;
        w_rd_byte = '0;
        for (int b = NUM_BYTES - 1; b >= 0; b--) begin
            if (OE[b]) begin
                w_oe_any  = 1'b1;
                w_rd_byte = r_count[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A load cycle never drives, so the block cannot fight its own source.
    assign data      = (CS && w_oe_any && !w_any_we) ? w_rd_byte : 'z;
    assign address   = OE_A ? r_count : 'z;
    assign count_out = r_count;

    assign zero   = (r_count == '0);
    assign carry  = (w_op == OP_INC) && (r_count == '1);
    assign borrow = (w_op == OP_DEC) && (r_count == '0);

endmodule

// File: tb/tb_addr_counter.sv
// Randomised and directed bench for addr_counter against an arithmetic model.
module tb_addr_counter;

    localparam int DW     = 8;
    localparam int NB     = 2;
    localparam int AW     = DW * NB;
    localparam int MOD    = 1 << AW;
    localparam int BYTE_M = (1 << DW) - 1;
    localparam logic [AW-1:0] RV = '0;

    logic          clk;
    logic          reset;
    logic          CS, OE_A, INC, DEC, REL;
    logic [NB-1:0] WE, OE;
    wire  [DW-1:0] data;
    logic [DW-1:0] tb_data;
    logic          tb_drv;
    wire  [AW-1:0] address;
    logic [AW-1:0] count_out;
    logic          carry, borrow, zero;

    int n_checks;
    int n_errors;
    int m_count;

    assign data = tb_drv ? tb_data : 'z;

    addr_counter #(
        .DATA_WIDTH  (DW),
        .NUM_BYTES   (NB),
        .RESET_VALUE (RV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .CS        (CS),
        .WE        (WE),
        .OE        (OE),
        .OE_A      (OE_A),
        .INC       (INC),
        .DEC       (DEC),
        .REL       (REL),
        .data      (data),
        .address   (address),
        .count_out (count_out),
        .carry     (carry),
        .borrow    (borrow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic undriven_d(input logic [DW-1:0] v);
        return (v === {DW{1'bz}}) || (v === {DW{1'b0}});
    endfunction

    function automatic logic undriven_a(input logic [AW-1:0] v);
        return (v === {AW{1'bz}}) || (v === {AW{1'b0}});
    endfunction

    // Address value after one clock, from plain integer arithmetic.
    function automatic int model_next(input int m, input logic cs, input logic [NB-1:0] we,
                                      input logic rel, input logic inc, input logic dec,
                                      input logic [DW-1:0] d);
        int r;
        int sd;
        r = m;
        if (!cs) return m;
        if (we != '0) begin
            for (int k = 0; k < NB; k++) begin
                if (we[k]) r = (r & ~(BYTE_M << (DW * k))) | (int'(d) << (DW * k));
            end
        end else if (rel) begin
            sd = (int'(d) >= (1 << (DW - 1))) ? int'(d) - (1 << DW) : int'(d);
            r  = (m + sd + MOD) % MOD;
        end else if (inc && !dec) begin
            r = (m + 1) % MOD;
        end else if (dec && !inc) begin
            r = (m + MOD - 1) % MOD;
        end
        return r;
    endfunction

    // Called right after a falling edge; returns right after the next falling edge.
    task automatic step(input logic cs, input logic [NB-1:0] we, input logic [NB-1:0] oe,
                        input logic oea, input logic inc, input logic dec, input logic rel,
                        input logic [DW-1:0] d);
        int   exp_k;
        logic drv;
        CS = cs; WE = we; OE = oe; OE_A = oea; INC = inc; DEC = dec; REL = rel;
        drv     = (we != '0) || rel;
        tb_drv  = drv;
        tb_data = d;
        #1;
        chk("count", count_out, m_count);
        chk("zero", zero, m_count == 0);
        chk("carry", carry, cs && inc && !dec && !rel && (we == '0) && (m_count == MOD - 1));
        chk("borrow", borrow, cs && dec && !inc && !rel && (we == '0) && (m_count == 0));
        if (oea) chk("address", address, m_count);
        else     chk("address_z", undriven_a(address), 1'b1);
        exp_k = -1;
        for (int k = NB - 1; k >= 0; k--) if (oe[k]) exp_k = k;
        if (drv)                      chk("data_src", data, d);
        else if (cs && exp_k >= 0)    chk("data_rd", data, (m_count >> (DW * exp_k)) & BYTE_M);
        else                          chk("data_z", undriven_d(data), 1'b1);
        @(posedge clk);
        m_count = model_next(m_count, cs, we, rel, inc, dec, d);
        @(negedge clk);
        tb_drv = 1'b0;
        chk("count_post", count_out, m_count);
    endtask

    logic [NB-1:0] r_we, r_oe;
    logic          r_cs, r_oea, r_inc, r_dec, r_rel;
    logic [DW-1:0] r_d;

    initial begin
        n_checks = 0;
        n_errors = 0;
        CS = 0; WE = '0; OE = '0; OE_A = 0; INC = 0; DEC = 0; REL = 0;
        tb_drv = 0; tb_data = '0;
        reset = 1'b0;
        m_count = int'(RV);
        @(negedge clk);
        @(negedge clk);
        chk("rst_count", count_out, 16'h0000);
        chk("rst_zero", zero, 1'b1);
        chk("rst_data_z", undriven_d(data), 1'b1);
        reset = 1'b1;

        step(1, 2'b00, 2'b00, 0, 1, 0, 0, 8'h00);
        chk("first_inc", count_out, 16'h0001);
        step(1, 2'b00, 2'b00, 0, 1, 0, 0, 8'h00);

        // Reset asserted mid-cycle with INC pending.
        CS = 1; INC = 1;
        #2 reset = 1'b0;
        #1;
        chk("midrst_count", count_out, 16'h0000);
        chk("midrst_zero", zero, 1'b1);
        @(posedge clk);
        #1;
        chk("rst_hold_edge", count_out, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        m_count = int'(RV);
        step(1, 2'b00, 2'b00, 0, 1, 0, 0, 8'h00);
        chk("post_rst_inc", count_out, 16'h0001);

        // Wrap up and down.
        step(1, 2'b11, 2'b00, 0, 0, 0, 0, 8'hFF);
        step(1, 2'b11, 2'b00, 0, 0, 0, 0, 8'hFF);
        chk("load_ff", count_out, 16'hFFFF);
        CS = 1; WE = '0; INC = 1; DEC = 0; REL = 0;
        #1 chk("carry_pre", carry, 1'b1);
        step(1, 2'b00, 2'b00, 0, 1, 0, 0, 8'h00);
        chk("wrap_up", count_out, 16'h0000);
        step(1, 2'b00, 2'b00, 0, 0, 1, 0, 8'h00);
        chk("wrap_down", count_out, 16'hFFFF);

        // Relative branch.
        step(1, 2'b01, 2'b00, 0, 0, 0, 0, 8'h00);
        step(1, 2'b10, 2'b00, 0, 0, 0, 0, 8'h10);
        chk("load_1000", count_out, 16'h1000);
        step(1, 2'b00, 2'b00, 1, 0, 0, 1, 8'hFE);
        chk("rel_neg", count_out, 16'h0FFE);
        step(1, 2'b00, 2'b00, 0, 0, 0, 1, 8'h05);
        chk("rel_pos", count_out, 16'h1003);

        // Priority of load over REL/INC, with drive suppressed.
        step(1, 2'b10, 2'b00, 0, 0, 0, 0, 8'hAB);
        step(1, 2'b01, 2'b00, 0, 0, 0, 0, 8'h00);
        chk("load_ab00", count_out, 16'hAB00);
        step(1, 2'b01, 2'b10, 0, 1, 0, 1, 8'h34);
        chk("prio_load", count_out, 16'hAB34);

        // Bus drive.
        step(1, 2'b10, 2'b00, 0, 0, 0, 0, 8'h12);
        step(1, 2'b01, 2'b00, 0, 0, 0, 0, 8'hEF);
        CS = 1; WE = '0; INC = 0; DEC = 0; REL = 0; OE_A = 0;
        OE = 2'b11;
        #1 chk("drv_lowest", data, 8'hEF);
        OE = 2'b10;
        #1 chk("drv_hi", data, 8'h12);
        CS = 0;
        #1 chk("drv_cs0_z", undriven_d(data), 1'b1);
        OE_A = 1;
        #1 chk("addr_cs0", address, 16'h12EF);
        @(negedge clk);
        step(0, 2'b00, 2'b11, 1, 1, 0, 0, 8'h00);
        chk("cs0_hold", count_out, 16'h12EF);

        // INC and DEC together hold.
        for (int i = 0; i < 3; i++) step(1, 2'b00, 2'b00, 0, 1, 1, 0, 8'h00);
        chk("incdec_hold", count_out, 16'h12EF);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            r_cs  = ($urandom_range(0, 7) != 0);
            r_we  = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0;
            r_rel = ($urandom_range(0, 5) == 0);
            r_inc = $urandom_range(0, 1);
            r_dec = $urandom_range(0, 1);
            r_oea = $urandom_range(0, 1);
            r_oe  = r_rel ? '0 : NB'($urandom);
            r_d   = DW'($urandom);
            step(r_cs, r_we, r_oe, r_oea, r_inc, r_dec, r_rel, r_d);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
